// File: rtl/neureka_normquant_seq_pkg.sv
// neureka_package: shared control types, mode encodings and sequencer state enum for the normquant sequencer
package neureka_package;
  localparam logic [1:0] NEUREKA_MODE_8B  = 2'd0;
  localparam logic [1:0] NEUREKA_MODE_16B = 2'd1;
  localparam logic [1:0] NEUREKA_MODE_32B = 2'd2;
  typedef struct packed {
    logic [1:0] norm_mode;
    logic       norm_signed;
  } ctrl_normquant_t;
  typedef enum logic [2:0] {
    NQ_IDLE,
    NQ_FETCH,
    NQ_WAIT,
    NQ_DRAIN,
    NQ_DONE
  } nq_seq_state_t;
endpackage

// File: rtl/neureka_normquant_seq.sv
// neureka_normquant_seq: block sequencer for the normquant datapath; optional stall counter via NEUREKA_NQ_PERF_CNT_EN
module neureka_normquant_seq
  import neureka_package::*;
#(
  parameter int NMULT = 4,
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_blocks_i,
  input  logic [1:0]       mode_i,
  input  logic             norm_signed_i,
  input  logic             norm_valid_i,
  output logic             norm_ready_o,
  input  logic             acc_valid_i,
  output logic             acc_ready_o,
  output logic             dp_load_o,
  output logic             dp_clear_o,
  output ctrl_normquant_t  dp_ctrl_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] block_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
`ifdef NEUREKA_NQ_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt_o
`endif
);
  if (LAT < 1 || LAT > 15 || NMULT < 1) begin : g_param_err
    $error("neureka_normquant_seq: LAT must be 1..15 and NMULT >= 1");
  end
  nq_seq_state_t    state, state_n;
  logic [CNT_W-1:0] n_blocks_q;
  logic [3:0]       wait_cnt;
  logic             start_ok, hs, accept, last;
  assign start_ok = (state == NQ_IDLE) & start_i & ~clear_i;
  assign hs       = (state == NQ_FETCH) & norm_valid_i & acc_valid_i & ~clear_i;
  assign accept   = (state == NQ_DRAIN) & out_ready_i & ~clear_i;
  assign last     = block_idx_o == n_blocks_q - CNT_W'(1);
  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= NQ_IDLE;
    else state <= state_n;
  end
  // next-state logic; an abort always returns to idle
  always_comb begin
    state_n = state;
    if (clear_i) state_n = NQ_IDLE;
    else
      case (state)
        NQ_IDLE:  if (start_i) state_n = (n_blocks_i == '0 || mode_i == 2'd3) ? NQ_DONE : NQ_FETCH;
        NQ_FETCH: if (hs) state_n = (LAT > 1) ? NQ_WAIT : NQ_DRAIN;
        NQ_WAIT:  if (wait_cnt == '0) state_n = NQ_DRAIN;
        NQ_DRAIN: if (accept) state_n = last ? NQ_DONE : NQ_FETCH;
        default:  state_n = NQ_IDLE;
      endcase
  end
  // handshake and status outputs
  always_comb begin
    norm_ready_o = hs;
    acc_ready_o  = hs;
    dp_load_o    = hs;
    out_valid_o  = (state == NQ_DRAIN) & ~clear_i;
    dp_clear_o   = ~rst_i & (clear_i | start_ok);
    busy_o       = state != NQ_IDLE;
    done_o       = state == NQ_DONE;
  end
  // job configuration latched at start, held for the whole job
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_blocks_q <= '0;
      dp_ctrl_o  <= '0;
    end else if (start_ok) begin
      n_blocks_q <= n_blocks_i;
      dp_ctrl_o  <= '{norm_mode: mode_i, norm_signed: norm_signed_i};
    end
  end
  // error flag survives DONE until the next accepted start or abort
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) err_o <= 1'b0;
    else if (start_ok) err_o <= mode_i == 2'd3;
  end
  // latency down-counter armed on the load handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) wait_cnt <= '0;
    else if (hs) wait_cnt <= (LAT > 1) ? 4'(LAT - 2) : 4'd0;
    else if (state == NQ_WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 4'd1;
  end
  // block index advances on each non-final result acceptance
  always_ff @(posedge clk_i) begin
    if (rst_i || state_n == NQ_IDLE) block_idx_o <= '0;
    else if (accept && !last) block_idx_o <= block_idx_o + CNT_W'(1);
  end
`ifdef NEUREKA_NQ_PERF_CNT_EN
  logic stall_inc;
  assign stall_inc = ((state == NQ_FETCH) & ~(norm_valid_i & acc_valid_i)) |
                     ((state == NQ_DRAIN) & ~out_ready_i);
  // saturating count of fetch starvation and drain backpressure cycles
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || start_ok) stall_cnt_o <= '0;
    else if (stall_inc && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif
endmodule

// File: tb/tb_neureka_normquant_seq.sv
// tb_neureka_normquant_seq: scenario and randomized checks of the normquant sequencer against a job-level model
module tb_neureka_normquant_seq;
  import neureka_package::*;
  localparam int LAT   = 2;
  localparam int CNT_W = 16;
  logic clk = 1'b0;
  logic rst_i, clear_i, start_i, norm_signed_i, norm_valid_i, acc_valid_i, out_ready_i;
  logic [CNT_W-1:0] n_blocks_i;
  logic [1:0] mode_i;
  logic norm_ready_o, acc_ready_o, dp_load_o, dp_clear_o, out_valid_o, busy_o, done_o, err_o;
  ctrl_normquant_t dp_ctrl_o;
  logic [CNT_W-1:0] block_idx_o;
`ifdef NEUREKA_NQ_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
`endif
  int checks = 0;
  int passed = 0;

  neureka_normquant_seq #(.NMULT(4), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .n_blocks_i(n_blocks_i), .mode_i(mode_i), .norm_signed_i(norm_signed_i),
    .norm_valid_i(norm_valid_i), .norm_ready_o(norm_ready_o),
    .acc_valid_i(acc_valid_i), .acc_ready_o(acc_ready_o),
    .dp_load_o(dp_load_o), .dp_clear_o(dp_clear_o), .dp_ctrl_o(dp_ctrl_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .block_idx_o(block_idx_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
`ifdef NEUREKA_NQ_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int n, input int m, input logic sg);
    n_blocks_i = CNT_W'(n);
    mode_i = 2'(m);
    norm_signed_i = sg;
  endtask

  task automatic finish_job();
    bit seen = 0;
    start_i = 0; clear_i = 0; norm_valid_i = 1; acc_valid_i = 1; out_ready_i = 1;
    for (int i = 0; i < 100 && !seen; i++) begin
      #4;
      if (done_o === 1'b1) seen = 1;
      step();
    end
    if (!seen) begin
      checks++;
      $display("FAIL finish_job_timeout got done never, exp done within 100 cycles");
    end
  endtask

  task automatic test_reset();
    rst_i = 1; clear_i = 1; start_i = 1; set_job(3, 1, 1);
    norm_valid_i = 1; acc_valid_i = 1; out_ready_i = 1;
    step(); step();
    #4;
    checks++; if ({busy_o, done_o, err_o, out_valid_o, dp_load_o, norm_ready_o, acc_ready_o, dp_clear_o} !== 8'b0)
      $display("FAIL reset_outputs got %b exp 00000000", {busy_o, done_o, err_o, out_valid_o, dp_load_o, norm_ready_o, acc_ready_o, dp_clear_o}); else passed++;
    checks++; if (block_idx_o !== '0 || dp_ctrl_o !== 3'b0)
      $display("FAIL reset_idx_ctrl got idx=%0d ctrl=%b exp 0/000", block_idx_o, dp_ctrl_o); else passed++;
    rst_i = 0; clear_i = 0; start_i = 0; norm_valid_i = 0; acc_valid_i = 0;
    step();
  endtask

  task automatic test_basic();
    logic el, eo, ed, eb, ec;
    set_job(3, 0, 0); norm_valid_i = 1; acc_valid_i = 1; out_ready_i = 1;
    for (int c = 0; c < 12; c++) begin
      start_i = (c == 0);
      #4;
      el = (c == 1 || c == 4 || c == 7);
      eo = (c == 3 || c == 6 || c == 9);
      ed = (c == 10);
      eb = (c >= 1 && c <= 10);
      ec = (c == 0);
      checks++; if (dp_load_o !== el) $display("FAIL basic_load c=%0d got %b exp %b", c, dp_load_o, el); else passed++;
      checks++; if (out_valid_o !== eo) $display("FAIL basic_out_valid c=%0d got %b exp %b", c, out_valid_o, eo); else passed++;
      checks++; if (done_o !== ed) $display("FAIL basic_done c=%0d got %b exp %b", c, done_o, ed); else passed++;
      checks++; if (busy_o !== eb) $display("FAIL basic_busy c=%0d got %b exp %b", c, busy_o, eb); else passed++;
      checks++; if (dp_clear_o !== ec) $display("FAIL basic_dp_clear c=%0d got %b exp %b", c, dp_clear_o, ec); else passed++;
      if (eo) begin
        checks++; if (block_idx_o !== CNT_W'((c - 3) / 3)) $display("FAIL basic_idx c=%0d got %0d exp %0d", c, block_idx_o, (c - 3) / 3); else passed++;
      end
      step();
    end
  endtask

  task automatic test_empty_and_illegal();
    set_job(0, 0, 0); start_i = 1; norm_valid_i = 1; acc_valid_i = 1;
    #4;
    checks++; if (dp_load_o !== 1'b0) $display("FAIL empty_load_c0 got %b exp 0", dp_load_o); else passed++;
    step(); start_i = 0; #4;
    checks++; if ({done_o, err_o, dp_load_o} !== 3'b100) $display("FAIL empty_done got done/err/load=%b exp 100", {done_o, err_o, dp_load_o}); else passed++;
    step(); #4;
    checks++; if ({busy_o, dp_load_o} !== 2'b00) $display("FAIL empty_after got busy/load=%b exp 00", {busy_o, dp_load_o}); else passed++;
    step();
    set_job(5, 3, 0); start_i = 1; step(); start_i = 0; #4;
    checks++; if ({done_o, err_o} !== 2'b11) $display("FAIL illegal_done got done/err=%b exp 11", {done_o, err_o}); else passed++;
    step();
    for (int c = 0; c < 3; c++) begin
      #4;
      checks++; if ({busy_o, err_o} !== 2'b01) $display("FAIL illegal_err_hold c=%0d got busy/err=%b exp 01", c, {busy_o, err_o}); else passed++;
      step();
    end
    set_job(1, 1, 0); start_i = 1; #4;
    checks++; if (err_o !== 1'b1) $display("FAIL illegal_err_at_start got %b exp 1", err_o); else passed++;
    step(); start_i = 0; #4;
    checks++; if ({busy_o, err_o} !== 2'b10) $display("FAIL illegal_err_cleared got busy/err=%b exp 10", {busy_o, err_o}); else passed++;
    finish_job();
  endtask

  task automatic test_fetch_stall();
    set_job(1, 2, 1); start_i = 1; norm_valid_i = 0; acc_valid_i = 1; out_ready_i = 1;
    step(); start_i = 0;
    for (int c = 1; c <= 5; c++) begin
      #4;
      checks++; if ({norm_ready_o, acc_ready_o, dp_load_o, busy_o} !== 4'b0001)
        $display("FAIL fetch_stall c=%0d got nr/ar/load/busy=%b exp 0001", c, {norm_ready_o, acc_ready_o, dp_load_o, busy_o}); else passed++;
      step();
    end
    norm_valid_i = 1; #4;
    checks++; if ({norm_ready_o, acc_ready_o, dp_load_o} !== 3'b111)
      $display("FAIL fetch_release got nr/ar/load=%b exp 111", {norm_ready_o, acc_ready_o, dp_load_o}); else passed++;
    step();
    finish_job();
`ifdef NEUREKA_NQ_PERF_CNT_EN
    checks++; if (stall_cnt_o !== 32'd5) $display("FAIL fetch_stall_cnt got %0d exp 5", stall_cnt_o); else passed++;
`endif
  endtask

  task automatic test_drain_stall();
    set_job(2, 0, 0); start_i = 1; norm_valid_i = 1; acc_valid_i = 1; out_ready_i = 0;
    step(); start_i = 0; step(); step();
    for (int c = 3; c <= 7; c++) begin
      out_ready_i = (c == 7);
      #4;
      checks++; if ({out_valid_o, block_idx_o} !== {1'b1, CNT_W'(0)})
        $display("FAIL drain_hold c=%0d got valid=%b idx=%0d exp valid=1 idx=0", c, out_valid_o, block_idx_o); else passed++;
      step();
    end
    #4;
    checks++; if ({out_valid_o, dp_load_o, block_idx_o} !== {2'b01, CNT_W'(1)})
      $display("FAIL drain_next got valid=%b load=%b idx=%0d exp 0/1/1", out_valid_o, dp_load_o, block_idx_o); else passed++;
`ifdef NEUREKA_NQ_PERF_CNT_EN
    checks++; if (stall_cnt_o !== 32'd4) $display("FAIL drain_stall_cnt got %0d exp 4", stall_cnt_o); else passed++;
`endif
    step();
    finish_job();
  endtask

  task automatic test_clear();
    set_job(3, 1, 0); start_i = 1; norm_valid_i = 1; acc_valid_i = 1; out_ready_i = 1;
    step(); start_i = 0;
    for (int c = 1; c < 5; c++) step();
    clear_i = 1; #4;
    checks++; if ({dp_clear_o, out_valid_o, norm_ready_o, dp_load_o, block_idx_o} !== {4'b1000, CNT_W'(1)})
      $display("FAIL clear_cycle got clr/ov/nr/load=%b idx=%0d exp 1000 idx=1", {dp_clear_o, out_valid_o, norm_ready_o, dp_load_o}, block_idx_o); else passed++;
    step(); clear_i = 0; #4;
    checks++; if ({busy_o, dp_clear_o, err_o, block_idx_o} !== {3'b000, CNT_W'(0)})
      $display("FAIL clear_after got busy/clr/err=%b idx=%0d exp 000 idx=0", {busy_o, dp_clear_o, err_o}, block_idx_o); else passed++;
    step();
    start_i = 1; clear_i = 1; step(); start_i = 0; clear_i = 0; #4;
    checks++; if (busy_o !== 1'b0) $display("FAIL clear_beats_start got busy=%b exp 0", busy_o); else passed++;
    step();
  endtask

  task automatic test_rst_mid();
    set_job(2, 2, 1); start_i = 1; norm_valid_i = 1; acc_valid_i = 1; out_ready_i = 0;
    step(); start_i = 0; step(); step();
    #4;
    checks++; if ({out_valid_o, dp_ctrl_o} !== 4'b1101) $display("FAIL rst_pre got valid/ctrl=%b exp 1101", {out_valid_o, dp_ctrl_o}); else passed++;
    rst_i = 1; step(); rst_i = 0; #4;
    checks++; if ({out_valid_o, busy_o, done_o, err_o, dp_load_o, norm_ready_o, acc_ready_o, dp_ctrl_o} !== 10'b0 || block_idx_o !== '0)
      $display("FAIL rst_mid got %b idx=%0d exp all 0", {out_valid_o, busy_o, done_o, err_o, dp_load_o, norm_ready_o, acc_ready_o, dp_ctrl_o}, block_idx_o); else passed++;
    out_ready_i = 1; step();
  endtask

  task automatic test_start_ignored();
    int loads = 0, ctrl_bad = 0;
    bit done_seen = 0;
    norm_valid_i = 1; acc_valid_i = 1; out_ready_i = 1;
    for (int c = 0; c < 40; c++) begin
      start_i = (c == 0 || c == 2);
      if (c == 0) set_job(2, 1, 0);
      if (c == 2) set_job(7, 3, 1);
      #4;
      if (dp_load_o === 1'b1) loads++;
      if (busy_o === 1'b1 && dp_ctrl_o !== 3'b010) ctrl_bad++;
      if (done_o === 1'b1) done_seen = 1;
      step();
    end
    start_i = 0;
    checks++; if (loads != 2) $display("FAIL ignored_start_loads got %0d exp 2", loads); else passed++;
    checks++; if (ctrl_bad != 0) $display("FAIL ignored_start_ctrl got %0d bad cycles exp 0", ctrl_bad); else passed++;
    checks++; if (!done_seen || err_o !== 1'b0) $display("FAIL ignored_start_done got done_seen=%0d err=%b exp 1/0", done_seen, err_o); else passed++;
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      int n = $urandom_range(1, 4);
      int m = $urandom_range(0, 2);
      logic sg = 1'($urandom_range(0, 1));
      bit active = 0, awaiting = 0, pending = 0, done_now = 0, done_next = 0, fin = 0;
      int idx = 0, load_c = 0, stalls = 0;
      logic nv, av, ordy, e_fetch, e_hs, e_ov;
      set_job(n, m, sg);
      start_i = 1; norm_valid_i = 0; acc_valid_i = 0; out_ready_i = 0;
      step(); start_i = 0;
      active = 1; awaiting = 1;
      for (int c = 1; c < 400 && !fin; c++) begin
        nv = ($urandom_range(0, 9) < 7);
        av = ($urandom_range(0, 9) < 7);
        ordy = ($urandom_range(0, 9) < 6);
        norm_valid_i = nv; acc_valid_i = av; out_ready_i = ordy;
        #4;
        e_fetch = active && awaiting;
        e_hs = e_fetch && nv && av;
        e_ov = active && pending && (c >= load_c + LAT);
        checks++; if ({dp_load_o, norm_ready_o, acc_ready_o} !== {3{e_hs}})
          $display("FAIL rand_hs j=%0d c=%0d got load/nr/ar=%b exp %b", j, c, {dp_load_o, norm_ready_o, acc_ready_o}, {3{e_hs}}); else passed++;
        checks++; if (out_valid_o !== e_ov) $display("FAIL rand_out_valid j=%0d c=%0d got %b exp %b", j, c, out_valid_o, e_ov); else passed++;
        checks++; if ({busy_o, done_o} !== {active | done_now, done_now})
          $display("FAIL rand_status j=%0d c=%0d got busy/done=%b exp %b", j, c, {busy_o, done_o}, {active | done_now, done_now}); else passed++;
        checks++; if (block_idx_o !== CNT_W'(idx) || dp_ctrl_o !== {2'(m), sg})
          $display("FAIL rand_idx_ctrl j=%0d c=%0d got idx=%0d ctrl=%b exp idx=%0d ctrl=%b", j, c, block_idx_o, dp_ctrl_o, idx, {2'(m), sg}); else passed++;
`ifdef NEUREKA_NQ_PERF_CNT_EN
        if (done_now) begin
          checks++; if (stall_cnt_o !== 32'(stalls)) $display("FAIL rand_stall_cnt j=%0d got %0d exp %0d", j, stall_cnt_o, stalls); else passed++;
        end
`endif
        stalls += int'(e_fetch && !(nv && av)) + int'(e_ov && !ordy);
        if (done_now) fin = 1;
        done_next = 0;
        if (e_hs) begin awaiting = 0; pending = 1; load_c = c; end
        if (e_ov && ordy) begin
          pending = 0;
          if (idx == n - 1) begin active = 0; done_next = 1; end
          else begin idx++; awaiting = 1; end
        end
        done_now = done_next;
        step();
      end
      if (!fin) begin
        checks++;
        $display("FAIL rand_timeout j=%0d got no done exp done within 400 cycles", j);
      end
    end
  endtask

  initial begin
    rst_i = 1; clear_i = 0; start_i = 0; set_job(0, 0, 0);
    norm_valid_i = 0; acc_valid_i = 0; out_ready_i = 0;
    test_reset();
    test_basic();
    test_empty_and_illegal();
    test_fetch_stall();
    test_drain_stall();
    test_clear();
    test_rst_mid();
    test_start_ignored();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/neureka_normquant_seq.md
NEUREKA_NORMQUANT_SEQ -- requirements
Module: neureka_normquant_seq

Interface
REQ-001 SHALL have parameter NMULT, default 4, number of normquant lanes sequenced (informational; fixes ctrl fan-out).
REQ-002 SHALL have parameter LAT, default 2, normquant datapath latency in cycles from load to valid result; legal range 1..15.
REQ-003 SHALL have parameter CNT_W, default 16, width of the block counter.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports, in this order:
 clk_i  in  1  clock
 rst_i  in  1  synchronous active-high reset
 clear_i  in  1  synchronous abort, active-high
 start_i  in  1  start pulse
 n_blocks_i  in  CNT_W  number of accumulator blocks to process
 mode_i  in  2  norm mode: 0=8b, 1=16b, 2=32b, 3=illegal
 norm_signed_i  in  1  signed norm multiplier
 norm_valid_i / norm_ready_o  in/out  1  norm_mult+shift parameter handshake
 acc_valid_i / acc_ready_o  in/out  1  accumulator block handshake
 dp_load_o  out  1  datapath operand load strobe
 dp_clear_o  out  1  datapath local clear
 dp_ctrl_o  out  ctrl_normquant_t  datapath control (norm_mode, norm_signed)
 out_valid_o / out_ready_i  out/in  1  result handshake to streamer
 block_idx_o  out  CNT_W  index of block currently in flight
 busy_o, done_o, err_o  out  1 each  status

Function
REQ-010 FSM states SHALL be IDLE, FETCH, WAIT, DRAIN, DONE.
REQ-011 IDLE: on start_i, latch n_blocks_i, mode_i, norm_signed_i; go FETCH next cycle; if n_blocks_i==0 or mode_i==3 go DONE instead, err_o=1 when mode_i==3.
REQ-012 start_i SHALL be ignored in every state except IDLE.
REQ-013 FETCH: norm_ready_o=acc_ready_o=(norm_valid_i & acc_valid_i); both handshakes SHALL complete in the same cycle, never one alone.
REQ-014 In the handshake cycle dp_load_o=1 (combinational); next state WAIT if LAT>1, else DRAIN.
REQ-015 WAIT SHALL last exactly LAT-1 cycles (internal down-counter), then DRAIN; first out_valid_o cycle is handshake cycle + LAT.
REQ-016 DRAIN: out_valid_o=1 held until out_ready_i; out_valid_o SHALL not drop before acceptance.
REQ-017 On DRAIN acceptance: if block_idx_o==n_blocks-1 go DONE, else increment block_idx_o and go FETCH.
REQ-018 DONE SHALL last one cycle with done_o=1, then IDLE; block_idx_o reset to 0 on entering IDLE.
REQ-019 busy_o=1 in every state except IDLE.
REQ-020 dp_ctrl_o SHALL carry latched mode/signed for the whole job, stable while busy_o.
REQ-021 dp_clear_o SHALL pulse one cycle on start acceptance and on clear_i.
REQ-022 clear_i in any state: next state IDLE, all handshake outputs 0 that cycle; err_o cleared; clear_i and start_i together: clear wins.
REQ-023 err_o SHALL stay 1 from DONE until next accepted start_i, reset or clear_i.

Reset
REQ-030 rst_i SHALL force IDLE; all outputs 0, block_idx_o=0, dp_ctrl_o='0, counters 0, at the next edge, including mid-job.
REQ-031 rst_i SHALL have priority over clear_i and start_i.

Configuration
REQ-040 Macro NEUREKA_NQ_PERF_CNT_EN: when defined, add output stall_cnt_o (32 bit) counting DRAIN cycles with out_ready_i=0 plus FETCH cycles lacking either valid; zeroed on start acceptance, reset, clear_i; saturates at all-ones.
REQ-041 Without the macro, the port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-050 ctrl_normquant_t, mode encodings (NEUREKA_MODE_8B/16B/32B) and a new nq_seq_state_t enum SHALL live in neureka_package.
REQ-051 Single module, no sub-module; latency counter and block counter inline.

Verification
REQ-060 LAT=2, n_blocks=3, mode=0, valids and out_ready always 1, start at cycle 0 -> dp_load_o cycles 1,4,7; out_valid_o cycles 3,6,9; done_o cycle 10; busy_o 1..10.
REQ-061 n_blocks=0 -> done_o cycle after start, no dp_load_o, err_o=0; mode=3 -> done_o and err_o=1, err_o held until next start.
REQ-062 acc_valid_i=1, norm_valid_i=0 for 5 cycles -> both ready outputs 0, no dp_load_o; norm_valid_i rises -> both readies 1 same cycle.
REQ-063 out_ready_i=0 for 4 cycles in DRAIN -> out_valid_o held 4+1 cycles, block_idx_o unchanged; with macro stall_cnt_o=4.
REQ-064 clear_i during WAIT of block 1 -> IDLE next cycle, dp_clear_o pulse, block_idx_o=0; rst_i during DRAIN -> all outputs 0 next cycle.
REQ-065 start_i asserted while busy -> ignored, latched n_blocks/mode unchanged, job completes as originally configured.
